// File: rtl/multi_cam_trig_pkg.sv
// Package: multi_cam_trig_pkg
// Shared constants and helpers for the multi-camera trigger sequencer.
//  - IDLE / RUN  : FSM state encodings
//  - MIN_PERIOD  : shortest legal frame length; guarantees one low clock per frame
//  - clamp_period / clamp_burst : sanitise raw register values at burst start
// Helpers work on a 64-bit container type, so callers must keep CNT_W <= 64.
package multi_cam_trig_pkg;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam int unsigned MIN_PERIOD = 2;
  localparam int unsigned MAX_CNT_W  = 64;

  typedef logic [MAX_CNT_W-1:0] cnt_max_t;

  // Periods below MIN_PERIOD would leave no room for the mandatory low clock.
  function automatic cnt_max_t clamp_period(input cnt_max_t p);
    return (p < cnt_max_t'(MIN_PERIOD)) ? cnt_max_t'(MIN_PERIOD) : p;
  endfunction

  // A burst always contains at least one frame.
  function automatic cnt_max_t clamp_burst(input cnt_max_t n);
    return (n == '0) ? cnt_max_t'(1) : n;
  endfunction

endpackage

// File: rtl/trig_ch_pulse.sv
// Module: trig_ch_pulse
// One camera channel: registered window decode of the frame counter plus the
// delayed one-cycle core pulse.
// Ports:
//  clk, rst     clock, synchronous active-high reset
//  run          sequencer is in RUN and not stopping this cycle
//  clear        abort/disable in RUN: drop the window and any pending core pulse
//  frame_cnt    position within the current frame
//  period       clamped frame length (>= 2)
//  high_time    camera pulse width
//  offset       channel start offset within the frame
//  core_delay   camera-rise to core-pulse delay (0 = same cycle as the rise)
//  ch_en        channel enable
//  cam          camera trigger level (one clock behind frame_cnt)
//  core         one-cycle core pulse
module trig_ch_pulse #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             clear,
  input  logic [CNT_W-1:0] frame_cnt,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] high_time,
  input  logic [CNT_W-1:0] offset,
  input  logic [CNT_W-1:0] core_delay,
  input  logic             ch_en,
  output logic             cam,
  output logic             core
);

  logic             cam_q, cam_d;
  logic             core_q, core_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [CNT_W:0]   off_x, end_x, lim_x, pos_x;
  logic             in_win;
  logic             rise;

  always_comb begin
    // One extra bit so offset + high_time cannot wrap.
    off_x = {1'b0, offset};
    lim_x = {1'b0, period} - {{CNT_W{1'b0}}, 1'b1};
    end_x = off_x + {1'b0, high_time};
    if (end_x > lim_x) begin
      end_x = lim_x;
    end
    pos_x  = {1'b0, frame_cnt};
    in_win = (pos_x >= off_x) && (pos_x < end_x);

    cam_d = run && ch_en && in_win;
    rise  = cam_d && !cam_q;

    cnt_d  = cnt_q;
    core_d = 1'b0;
    if (rise) begin
      // A fresh rise restarts the delay; an older pending pulse is lost.
      cnt_d = core_delay;
      if (core_delay == '0) begin
        core_d = 1'b1;
      end
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        core_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cam_q  <= 1'b0;
      core_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      cam_q  <= cam_d;
      core_q <= core_d;
      cnt_q  <= cnt_d;
    end
  end

  assign cam  = cam_q;
  assign core = core_q;

endmodule

// File: rtl/multi_cam_trigger_seq.sv
// Module: multi_cam_trigger_seq
// Burst trigger sequencer for NUM_CH cameras. A rising edge on trigger_in (after
// synchronisation) or a sw_trig pulse starts a burst of reg_burst_num frames of
// reg_period clocks; in free-run mode bursts repeat until abort/disable.
// Each frame drives staggered camera pulses and delayed core pulses per channel.
// Ports:
//  clk, rst        clock, synchronous active-high reset
//  enable          low acts as abort and blocks starts
//  mode            0 = edge-burst, 1 = free-run
//  trigger_in      asynchronous external trigger, rising-edge active
//  sw_trig         one-cycle software start (clk domain)
//  abort           stop immediately
//  reg_*           timing registers, sampled into shadows at burst start
//  ch_enable       channel mask, shadowed at burst start
//  trig_to_camera  camera trigger levels
//  trig_to_core    one-cycle core pulses
//  busy            high in RUN
//  burst_done      pulse at the end of the last frame of a burst
//  missed_trig     pulse when a start request arrives during an edge-burst
//  frame_idx       frame index within the current burst
// CNT_W must not exceed 64 (width of the clamp helpers).
module multi_cam_trigger_seq
  import multi_cam_trig_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    mode,
  input  logic                    trigger_in,
  input  logic                    sw_trig,
  input  logic                    abort,
  input  logic [CNT_W-1:0]        reg_period,
  input  logic [CNT_W-1:0]        reg_burst_num,
  input  logic [CNT_W-1:0]        reg_high_time,
  input  logic [NUM_CH*CNT_W-1:0] reg_ch_offset,
  input  logic [NUM_CH*CNT_W-1:0] reg_core_delay,
  input  logic [NUM_CH-1:0]       ch_enable,
  output logic [NUM_CH-1:0]       trig_to_camera,
  output logic [NUM_CH-1:0]       trig_to_core,
  output logic                    busy,
  output logic                    burst_done,
  output logic                    missed_trig,
  output logic [CNT_W-1:0]        frame_idx
);

  // Trigger synchroniser and edge detect
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   trig_prev_q;
  logic                   hw_rise;
  logic                   start_req;

  assign hw_rise   = sync_q[SYNC_STAGES-1] && !trig_prev_q;
  // A simultaneous HW edge and sw_trig collapse into one request.
  assign start_req = hw_rise || sw_trig;

  // FSM, counters and shadows
  logic [0:0]              state_q, state_d;
  logic [CNT_W-1:0]        frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0]        frame_idx_q, frame_idx_d;
  logic                    done_q, done_d;
  logic                    missed_q, missed_d;

  logic [CNT_W-1:0]        period_q;
  logic [CNT_W-1:0]        burst_q;
  logic [CNT_W-1:0]        high_q;
  logic [NUM_CH*CNT_W-1:0] offset_q;
  logic [NUM_CH*CNT_W-1:0] delay_q;
  logic [NUM_CH-1:0]       ch_en_q;
  logic                    mode_q;

  logic [CNT_W-1:0]        period_clamped;
  logic [CNT_W-1:0]        burst_clamped;
  logic                    stop;
  logic                    start;
  logic                    wrap;
  logic                    last_frame;
  logic                    ch_run;
  logic                    ch_clear;

  assign period_clamped = CNT_W'(clamp_period(cnt_max_t'(reg_period)));
  assign burst_clamped  = CNT_W'(clamp_burst(cnt_max_t'(reg_burst_num)));

  assign stop       = abort || !enable;
  assign start      = (state_q == IDLE) && enable && !abort && (start_req || mode);
  assign wrap       = (frame_cnt_q == period_q - CNT_W'(1));
  assign last_frame = ((frame_idx_q + CNT_W'(1)) == burst_q);

  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    frame_idx_d = frame_idx_q;
    done_d      = 1'b0;
    missed_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = RUN;
          frame_cnt_d = '0;
          frame_idx_d = '0;
        end
      end
      RUN: begin
        if (stop) begin
          // Abort beats a same-cycle wrap: no burst_done.
          state_d     = IDLE;
          frame_cnt_d = '0;
          frame_idx_d = '0;
        end else begin
          if (start_req && !mode_q) begin
            missed_d = 1'b1;
          end
          if (wrap) begin
            frame_cnt_d = '0;
            if (last_frame) begin
              done_d      = 1'b1;
              frame_idx_d = '0;
              if (!mode_q) begin
                state_d = IDLE;
              end
            end else begin
              frame_idx_d = frame_idx_q + CNT_W'(1);
            end
          end else begin
            frame_cnt_d = frame_cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q      <= '0;
      trig_prev_q <= 1'b0;
      state_q     <= IDLE;
      frame_cnt_q <= '0;
      frame_idx_q <= '0;
      done_q      <= 1'b0;
      missed_q    <= 1'b0;
      period_q    <= CNT_W'(MIN_PERIOD);
      burst_q     <= CNT_W'(1);
      high_q      <= '0;
      offset_q    <= '0;
      delay_q     <= '0;
      ch_en_q     <= '0;
      mode_q      <= 1'b0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], trigger_in};
      trig_prev_q <= sync_q[SYNC_STAGES-1];
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      frame_idx_q <= frame_idx_d;
      done_q      <= done_d;
      missed_q    <= missed_d;
      if (start) begin
        period_q <= period_clamped;
        burst_q  <= burst_clamped;
        high_q   <= reg_high_time;
        offset_q <= reg_ch_offset;
        delay_q  <= reg_core_delay;
        ch_en_q  <= ch_enable;
        mode_q   <= mode;
      end
    end
  end

  // Channels see the stop in the same cycle, so outputs drop at the next edge.
  assign ch_run   = (state_q == RUN) && !stop;
  assign ch_clear = (state_q == RUN) && stop;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    trig_ch_pulse #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .run        (ch_run),
      .clear      (ch_clear),
      .frame_cnt  (frame_cnt_q),
      .period     (period_q),
      .high_time  (high_q),
      .offset     (offset_q[i*CNT_W +: CNT_W]),
      .core_delay (delay_q[i*CNT_W +: CNT_W]),
      .ch_en      (ch_en_q[i]),
      .cam        (trig_to_camera[i]),
      .core       (trig_to_core[i])
    );
  end

  assign busy        = (state_q == RUN);
  assign burst_done  = done_q;
  assign missed_trig = missed_q;
  assign frame_idx   = frame_idx_q;

endmodule

// File: tb/tb_multi_cam_trigger_seq.sv
// Testbench for multi_cam_trigger_seq. Expected output events (camera rise/fall,
// core pulse, burst_done, missed_trig) with their cycle numbers are pushed to a
// scoreboard when stimulus is driven; a negedge monitor pops and compares them.
module tb_multi_cam_trigger_seq;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 32;
  localparam int SYNC   = 2;
  localparam int BIG    = 1000000;

  localparam int K_RISE = 0;
  localparam int K_FALL = 1;
  localparam int K_CORE = 2;
  localparam int K_DONE = 3;
  localparam int K_MISS = 4;

  logic clk = 1'b0;
  logic rst, enable, mode, trigger_in, sw_trig, abort;
  logic [CNT_W-1:0]        reg_period, reg_burst_num, reg_high_time;
  logic [NUM_CH*CNT_W-1:0] reg_ch_offset, reg_core_delay;
  logic [NUM_CH-1:0]       ch_enable, trig_to_camera, trig_to_core;
  logic                    busy, burst_done, missed_trig;
  logic [CNT_W-1:0]        frame_idx;

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;

  typedef struct {int kind; int ch; int cyc;} ev_t;
  ev_t exp_q[$];
  string kname [5] = '{"rise", "fall", "core", "done", "missed"};

  // Model configuration (what the bench believes the shadows hold)
  int m_p, m_n, m_h;
  int m_off [NUM_CH];
  int m_dly [NUM_CH];
  logic [NUM_CH-1:0] m_en;

  multi_cam_trigger_seq #(
    .NUM_CH      (NUM_CH),
    .CNT_W       (CNT_W),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .mode           (mode),
    .trigger_in     (trigger_in),
    .sw_trig        (sw_trig),
    .abort          (abort),
    .reg_period     (reg_period),
    .reg_burst_num  (reg_burst_num),
    .reg_high_time  (reg_high_time),
    .reg_ch_offset  (reg_ch_offset),
    .reg_core_delay (reg_core_delay),
    .ch_enable      (ch_enable),
    .trig_to_camera (trig_to_camera),
    .trig_to_core   (trig_to_core),
    .busy           (busy),
    .burst_done     (burst_done),
    .missed_trig    (missed_trig),
    .frame_idx      (frame_idx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input longint got, input longint want);
    n_checks++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, want);
  endtask

  task automatic push_ev(input int kind, input int ch, input int c);
    ev_t e;
    e.kind = kind;
    e.ch   = ch;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  task automatic match_ev(input int kind, input int ch, input int c);
    int best;
    best = -1;
    foreach (exp_q[i]) begin
      if (exp_q[i].kind == kind && exp_q[i].ch == ch &&
          (best < 0 || exp_q[i].cyc < exp_q[best].cyc)) best = i;
    end
    if (best < 0) begin
      check($sformatf("unexpected_%s%0d", kname[kind], ch), c, -1);
    end else begin
      check($sformatf("%s%0d", kname[kind], ch), c, exp_q[best].cyc);
      exp_q.delete(best);
    end
  endtask

  // Expected events for a burst starting at edge se; nothing at or after cut.
  task automatic push_burst(input int se, input bit free, input int cut);
    int p, n, nf, endw, r, f, c;
    int rises[$];
    p  = (m_p < 2) ? 2 : m_p;
    n  = (m_n == 0) ? 1 : m_n;
    nf = free ? ((cut - se) / p + 1) : n;
    if (free) begin
      for (int j = 1; se + p * n * j < cut; j++) push_ev(K_DONE, 0, se + p * n * j);
    end else if (se + p * n < cut) begin
      push_ev(K_DONE, 0, se + p * n);
    end
    for (int ch = 0; ch < NUM_CH; ch++) begin
      endw = m_off[ch] + m_h;
      if (endw > p - 1) endw = p - 1;
      if (m_en[ch] && m_off[ch] < endw) begin
        rises.delete();
        for (int k = 0; k < nf; k++) begin
          r = se + 1 + m_off[ch] + p * k;
          f = se + 1 + endw + p * k;
          if (r >= cut) break;
          push_ev(K_RISE, ch, r);
          push_ev(K_FALL, ch, (f < cut) ? f : cut);
          rises.push_back(r);
        end
        for (int k = 0; k < rises.size(); k++) begin
          c = rises[k] + m_dly[ch];
          if ((k == rises.size() - 1 || c < rises[k+1]) && c < cut) push_ev(K_CORE, ch, c);
        end
      end
    end
  endtask

  task automatic cfg(input int p, input int n, input int h,
                     input int o0, input int o1, input int o2, input int o3,
                     input int d0, input int d1, input int d2, input int d3,
                     input logic [NUM_CH-1:0] en);
    m_p = p; m_n = n; m_h = h; m_en = en;
    m_off[0] = o0; m_off[1] = o1; m_off[2] = o2; m_off[3] = o3;
    m_dly[0] = d0; m_dly[1] = d1; m_dly[2] = d2; m_dly[3] = d3;
    reg_period    = m_p;
    reg_burst_num = m_n;
    reg_high_time = m_h;
    ch_enable     = m_en;
    for (int i = 0; i < NUM_CH; i++) begin
      reg_ch_offset[i*CNT_W +: CNT_W]  = m_off[i];
      reg_core_delay[i*CNT_W +: CNT_W] = m_dly[i];
    end
  endtask

  // Pulses sw_trig for one cycle; returns the start edge.
  task automatic sw_start(output int se);
    @(negedge clk);
    se = cyc + 1;
    sw_trig = 1'b1;
    @(negedge clk);
    sw_trig = 1'b0;
  endtask

  logic [NUM_CH-1:0] cam_prev = '0;
  always @(negedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (trig_to_camera[i] && !cam_prev[i]) match_ev(K_RISE, i, cyc);
      if (!trig_to_camera[i] && cam_prev[i]) match_ev(K_FALL, i, cyc);
      if (trig_to_core[i]) match_ev(K_CORE, i, cyc);
    end
    if (burst_done) match_ev(K_DONE, 0, cyc);
    if (missed_trig) match_ev(K_MISS, 0, cyc);
    cam_prev <= trig_to_camera;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got 0 expected 1");
    $fatal(1, "timeout");
  end

  initial begin
    int c, se, a;
    rst = 1'b1; enable = 1'b1; mode = 1'b0; trigger_in = 1'b0; sw_trig = 1'b0; abort = 1'b0;
    cfg(10, 3, 4, 0, 2, 4, 6, 3, 3, 3, 3, 4'hf);
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_cam", trig_to_camera, 0);
    check("rst_core", trig_to_core, 0);
    check("rst_done", burst_done, 0);
    check("rst_missed", missed_trig, 0);
    check("rst_frame_idx", frame_idx, 0);
    rst = 1'b0;

    // HW-triggered burst, with a second edge mid-burst
    @(negedge clk);
    c = cyc;
    trigger_in = 1'b1;
    push_burst(c + 1 + SYNC, 0, BIG);
    repeat (3) @(negedge clk);
    check("busy_run", busy, 1);
    trigger_in = 1'b0;
    repeat (12) @(negedge clk);
    check("frame_idx_1", frame_idx, 1);
    trigger_in = 1'b1;
    push_ev(K_MISS, 0, cyc + 1 + SYNC);
    repeat (3) @(negedge clk);
    trigger_in = 1'b0;
    repeat (30) @(negedge clk);
    check("idle_after_burst", busy, 0);
    check("q_empty_hw", exp_q.size(), 0);

    // New edge once IDLE starts a fresh burst
    cfg(10, 1, 4, 0, 2, 4, 6, 3, 3, 3, 3, 4'hf);
    @(negedge clk);
    c = cyc;
    trigger_in = 1'b1;
    push_burst(c + 1 + SYNC, 0, BIG);
    repeat (3) @(negedge clk);
    trigger_in = 1'b0;
    repeat (20) @(negedge clk);
    check("q_empty_rearm", exp_q.size(), 0);

    // Free-run, N=2, abort during frame 5; sw_trig mid-run is silent
    cfg(10, 2, 4, 0, 2, 4, 6, 3, 3, 3, 3, 4'hf);
    @(negedge clk);
    se = cyc + 1;
    a  = se + 54;
    mode = 1'b1;
    push_burst(se, 1, a);
    repeat (se + 25 - cyc) @(negedge clk);
    sw_trig = 1'b1;
    @(negedge clk);
    sw_trig = 1'b0;
    repeat (a - 1 - cyc) @(negedge clk);
    abort = 1'b1;
    mode  = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_cam", trig_to_camera, 0);
    check("abort_core", trig_to_core, 0);
    abort = 1'b0;
    repeat (10) @(negedge clk);
    check("q_empty_freerun", exp_q.size(), 0);

    // period=1 -> 2, burst=0 -> 1, high truncated, off=P-1 silent
    cfg(1, 0, 20, 0, 1, 0, 0, 0, 0, 0, 0, 4'hf);
    sw_start(se);
    push_burst(se, 0, BIG);
    repeat (8) @(negedge clk);
    check("q_empty_p1", exp_q.size(), 0);
    check("idle_p1", busy, 0);

    cfg(10, 1, 20, 9, 0, 3, 8, 0, 1, 2, 5, 4'b1011);
    sw_start(se);
    push_burst(se, 0, BIG);
    repeat (20) @(negedge clk);
    check("q_empty_trunc", exp_q.size(), 0);

    cfg(10, 1, 0, 0, 2, 4, 6, 3, 3, 3, 3, 4'hf);
    sw_start(se);
    push_burst(se, 0, BIG);
    repeat (15) @(negedge clk);
    check("q_empty_high0", exp_q.size(), 0);

    // Rises closer than core_delay: only the last core pulse survives
    cfg(2, 3, 1, 0, 0, 0, 0, 3, 3, 3, 3, 4'b0001);
    sw_start(se);
    push_burst(se, 0, BIG);
    repeat (15) @(negedge clk);
    check("q_empty_restart", exp_q.size(), 0);

    // Shadowing: mid-burst register changes apply at the next start only
    cfg(10, 2, 4, 0, 2, 4, 6, 1, 1, 1, 1, 4'hf);
    sw_start(se);
    push_burst(se, 0, BIG);
    repeat (2) @(negedge clk);
    cfg(10, 2, 2, 5, 5, 5, 5, 1, 1, 1, 1, 4'b0001);
    repeat (25) @(negedge clk);
    check("q_empty_shadow_old", exp_q.size(), 0);
    sw_start(se);
    push_burst(se, 0, BIG);
    repeat (25) @(negedge clk);
    check("q_empty_shadow_new", exp_q.size(), 0);

    // Reset mid-RUN with core pulses pending
    cfg(10, 1, 4, 0, 0, 0, 0, 5, 5, 5, 5, 4'hf);
    sw_start(se);
    push_burst(se, 0, se + 3);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_busy", busy, 0);
    check("rstmid_cam", trig_to_camera, 0);
    check("rstmid_core", trig_to_core, 0);
    check("rstmid_frame_idx", frame_idx, 0);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("q_empty_rstmid", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
